ahb_arbiter_rr: RTL and testbench
=================================

Name: ahb_arbiter_rr

Overview:
Parametrised next-generation AHB bus arbiter for NUM_MASTERS masters. It supports two arbitration modes: fixed priority and round-robin. It handles locked transfers and SPLIT masking driven from HRESP/HSPLIT. A hold-limit counter forces re-arbitration so no master can starve the others. It sits between the master request/grant lines and the address/data mux select (HMASTER) in the AHB interconnect.

Parameters:
NUM_MASTERS, 16, number of masters (2..16)
MASTER_W, $clog2(NUM_MASTERS), width of HMASTER
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
DEFAULT_MASTER, 0, master granted when no eligible request
MAX_HOLD, 8, max consecutive HREADY beats one owner keeps the bus while others wait; 0 = unlimited

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESET  in  1  asynchronous, active-high reset
HBUSREQx  in  NUM_MASTERS  bus request per master
HLOCKx  in  NUM_MASTERS  locked-transfer request per master
HSPLIT  in  NUM_MASTERS  slave split-resume, clears the mask bit of master i
HRESP  in  2  slave response (2'b11 = SPLIT)
HREADY  in  1  transfer complete; arbitration outputs advance only when high
HGRANTx  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  MASTER_W  current address-phase owner, registered
HMASTLOCK  out  1  current transfer locked, registered
SPLITMASK  out  NUM_MASTERS  split-masked masters (debug/verification visibility)

Behaviour:
- Reset (async, HRESET=1):
  - HGRANTx = one-hot(DEFAULT_MASTER)
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - SPLITMASK = 0
  - hold counter = 0
  - RR pointer = DEFAULT_MASTER
- HGRANTx is always exactly one-hot; never zero, never multi-hot.
- Eligible set = HBUSREQx & ~SPLITMASK.
- Hold-off: when HREADY=0, HGRANTx, HMASTER, HMASTLOCK, counter and pointer all hold.
- On each edge with HREADY=1:
  - HMASTER <= index of the current HGRANTx (grant-to-address-phase latency = 1 HREADY cycle).
  - HMASTLOCK <= HLOCKx[current owner].
- Grant decision, in priority order:
  - Lock hold: if HLOCKx[owner]=1, the grant stays. The counter neither advances nor expires.
  - Continue: if owner is eligible, and either the counter < MAX_HOLD or no other master is eligible, the grant stays.
  - Else arbitrate over the eligible set:
    - ARB_MODE=0: lowest index wins.
    - ARB_MODE=1: first eligible index searching from (pointer+1) mod NUM_MASTERS upward with wrap. Pointer <= winner.
  - Empty eligible set: grant DEFAULT_MASTER (dummy owner), even if DEFAULT_MASTER is masked.
- Hold counter:
  - Increments on HREADY beats while the owner is unchanged; saturates at MAX_HOLD.
  - Clears to 0 on any grant change.
  - MAX_HOLD=0 disables expiry.
  - A forced handover occurs only when another master is eligible.
- SPLIT:
  - On an edge with HREADY=1 and HRESP=2'b11, SPLITMASK[HMASTER] <= 1.
  - The same edge re-arbitrates with that master excluded.
- Split-resume:
  - HSPLIT[i]=1 on any edge clears SPLITMASK[i], independent of HREADY.
  - Simultaneous set and clear of the same bit: clear wins (no deadlock).
- Out-of-range bits: requests from masters ≥ NUM_MASTERS do not exist. Tie-offs and width follow NUM_MASTERS.
- Reset mid-burst or mid-lock: everything returns to reset values immediately. Lock and masks are not remembered.
- Fairness: in ARB_MODE=1, a continuously requesting unmasked, unlocked master is granted within (NUM_MASTERS-1)*(MAX_HOLD+1)+1 HREADY beats.

Test Plan:
- Reset, then no requests → HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0 held for 20 cycles. Assert one-hot on every edge.
- ARB_MODE=1, HBUSREQx=16'h000E held, HREADY=1, MAX_HOLD=2 → owner sequence 1,1,1,2,2,2,3,3,3,1…. HMASTER lags HGRANTx by one cycle.
- ARB_MODE=0, requests 16'h0006 → master 1 keeps the grant for 3 beats, then master 2 gets it for 3 beats, alternating. Drop req[1] → master 2 keeps the bus indefinitely.
- Master 3 HLOCKx=1 with HBUSREQx=16'hFFFF for 20 beats → HGRANTx stays 16'h0008 and HMASTLOCK=1 from the second beat. Release the lock → handover to master 4 (RR).
- Owner 5 receives HRESP=2'b11 with HREADY=1 → SPLITMASK=16'h0020 and master 5 is ungranted despite requesting. HSPLIT[5] pulse → mask clears and master 5 is granted within the RR bound. Same-cycle set and clear → mask stays 0.
- HRESET asserted mid-locked burst with HREADY=0 → outputs return to reset values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter for NUM_MASTERS masters: fixed-priority or round-robin selection,
// locked-transfer hold, SPLIT masking and a hold-limit counter that forces handover.
module ahb_arbiter_rr #(
    parameter int NUM_MASTERS    = 16,
    parameter int MASTER_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int ARB_MODE       = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic [1:0]             HRESP,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MASTER_W-1:0]    HMASTER,
    output logic                   HMASTLOCK,
    output logic [NUM_MASTERS-1:0] SPLITMASK
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0]       hold_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       cnt_next;
    logic [MASTER_W-1:0]    ptr;
    logic [MASTER_W-1:0]    ptr_next;
    logic [MASTER_W-1:0]    owner;
    logic [NUM_MASTERS-1:0] split_set;
    logic [NUM_MASTERS-1:0] mask_next;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] candidates;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [MASTER_W-1:0]    fp_idx;
    logic [MASTER_W-1:0]    rr_idx;
    logic [MASTER_W-1:0]    rr_probe;
    logic [MASTER_W-1:0]    win_idx;
    logic                   rr_found;
    logic                   hold_expired;
    logic                   others_waiting;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANTx[i]) begin
                owner = MASTER_W'(i);
            end
        end
    end

    // A SPLIT response masks the address-phase owner; a resume for the same bit wins.
    always_comb begin
        split_set = '0;
        if (HREADY && (HRESP == 2'b11)) begin
            split_set[HMASTER] = 1'b1;
        end
    end

    assign mask_next      = (SPLITMASK | split_set) & ~HSPLIT;
    assign eligible       = HBUSREQx & ~mask_next;
    assign candidates     = eligible & ~HGRANTx;
    assign others_waiting = |candidates;
    assign hold_expired   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIMIT);
    assign cnt_inc        = (hold_cnt >= HOLD_LIMIT) ? hold_cnt : hold_cnt + CNT_W'(1);

    always_comb begin
        fp_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                fp_idx = MASTER_W'(i);
            end
        end
    end

    // Round-robin search starts just after the last winner and wraps once around.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_probe = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_probe = MASTER_W'((int'(ptr) + k) % NUM_MASTERS);
            if (!rr_found && candidates[rr_probe]) begin
                rr_found = 1'b1;
                rr_idx   = rr_probe;
            end
        end
    end

    always_comb begin
        win_idx         = (ARB_MODE == 1) ? rr_idx : fp_idx;
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        grant_next = HGRANTx;
        cnt_next   = hold_cnt;
        ptr_next   = ptr;
        if (HLOCKx[owner]) begin
            grant_next = HGRANTx;
        end else if (eligible[owner] && (!hold_expired || !others_waiting)) begin
            cnt_next = cnt_inc;
        end else if (others_waiting) begin
            grant_next = win_oh;
            cnt_next   = '0;
            if (ARB_MODE == 1) begin
                ptr_next = win_idx;
            end
        end else begin
            grant_next = DEFAULT_OH;
            cnt_next   = (HGRANTx == DEFAULT_OH) ? cnt_inc : '0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANTx   <= DEFAULT_OH;
            HMASTER   <= MASTER_W'(DEFAULT_MASTER);
            HMASTLOCK <= 1'b0;
            SPLITMASK <= '0;
            hold_cnt  <= '0;
            ptr       <= MASTER_W'(DEFAULT_MASTER);
        end else begin
            SPLITMASK <= mask_next;
            if (HREADY) begin
                HGRANTx   <= grant_next;
                HMASTER   <= owner;
                HMASTLOCK <= HLOCKx[owner];
                hold_cnt  <= cnt_next;
                ptr       <= ptr_next;
            end
        end
    end

    grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANTx));

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share random and directed
// stimulus; a rule-level model predicts each beat and a monitor compares both DUTs.
module tb_ahb_arbiter_rr;

    localparam int N    = 16;
    localparam int MW   = 4;
    localparam int MAXH = 2;
    localparam int DEFM = 0;

    logic          HCLK     = 1'b0;
    logic          HRESET   = 1'b1;
    logic [N-1:0]  HBUSREQx = '0;
    logic [N-1:0]  HLOCKx   = '0;
    logic [N-1:0]  HSPLIT   = '0;
    logic [1:0]    HRESP    = 2'b00;
    logic          HREADY   = 1'b1;

    logic [N-1:0]  rr_grant, fp_grant, rr_mask, fp_mask;
    logic [MW-1:0] rr_master, fp_master;
    logic          rr_lock, fp_lock;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [MW-1:0] master;
        logic          lock;
        logic [N-1:0]  mask;
    } exp_t;

    exp_t exp_rr[$];
    exp_t exp_fp[$];
    int   checks = 0;
    int   errors = 0;

    // Model state per arbitration mode (index 0 = fixed priority, 1 = round-robin).
    int           m_owner[2];
    int           m_master[2];
    int           m_cnt[2];
    int           m_ptr[2];
    logic         m_lock[2];
    logic [N-1:0] m_mask[2];

    ahb_arbiter_rr #(.NUM_MASTERS(N), .ARB_MODE(1), .DEFAULT_MASTER(DEFM), .MAX_HOLD(MAXH)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(rr_grant), .HMASTER(rr_master),
        .HMASTLOCK(rr_lock), .SPLITMASK(rr_mask)
    );

    ahb_arbiter_rr #(.NUM_MASTERS(N), .ARB_MODE(0), .DEFAULT_MASTER(DEFM), .MAX_HOLD(MAXH)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(fp_grant), .HMASTER(fp_master),
        .HMASTLOCK(fp_lock), .SPLITMASK(fp_mask)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic bitAt(input logic [N-1:0] v, input int i);
        logic [31:0] idx;
        idx = i;
        return v[idx[MW-1:0]];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int md = 0; md < 2; md++) begin
            m_owner[md]  = DEFM;
            m_master[md] = DEFM;
            m_cnt[md]    = 0;
            m_ptr[md]    = DEFM;
            m_lock[md]   = 1'b0;
            m_mask[md]   = '0;
        end
    endtask

    // One rising edge of the arbiter, expressed as the bus rules rather than gates.
    task automatic modelStep(input int md);
        logic [N-1:0] mask_after;
        logic [N-1:0] elig;
        int           others;
        int           winner;
        int           idx;
        int           cur;
        if (!HREADY) begin
            m_mask[md] = m_mask[md] & ~HSPLIT;
            return;
        end
        mask_after = m_mask[md];
        if (HRESP == 2'b11) mask_after = mask_after | (N'(1) << m_master[md]);
        mask_after = mask_after & ~HSPLIT;
        elig       = HBUSREQx & ~mask_after;
        cur        = m_owner[md];
        others     = 0;
        for (int i = 0; i < N; i++) begin
            if (bitAt(elig, i) && i != cur) others++;
        end
        m_master[md] = cur;
        m_lock[md]   = bitAt(HLOCKx, cur);
        if (bitAt(HLOCKx, cur)) begin
            m_cnt[md] = m_cnt[md];
        end else if (bitAt(elig, cur) && (m_cnt[md] < MAXH || others == 0)) begin
            m_cnt[md] = (m_cnt[md] < MAXH) ? m_cnt[md] + 1 : MAXH;
        end else if (others > 0) begin
            winner = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (md == 1) ? (m_ptr[md] + k) % N : k - 1;
                if (winner < 0 && bitAt(elig, idx) && idx != cur) winner = idx;
            end
            m_owner[md] = winner;
            m_cnt[md]   = 0;
            if (md == 1) m_ptr[md] = winner;
        end else if (cur == DEFM) begin
            m_cnt[md] = (m_cnt[md] < MAXH) ? m_cnt[md] + 1 : MAXH;
        end else begin
            m_owner[md] = DEFM;
            m_cnt[md]   = 0;
        end
        m_mask[md] = mask_after;
    endtask

    function automatic exp_t expOf(input int md);
        exp_t e;
        e.grant  = N'(1) << m_owner[md];
        e.master = MW'(m_master[md]);
        e.lock   = m_lock[md];
        e.mask   = m_mask[md];
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                                 input logic [N-1:0] split, input logic [1:0] resp, input logic ready);
        @(negedge HCLK);
        HRESET   = rst;
        HBUSREQx = req;
        HLOCKx   = lock;
        HSPLIT   = split;
        HRESP    = resp;
        HREADY   = ready;
        if (rst) begin
            modelReset();
        end else begin
            modelStep(0);
            modelStep(1);
        end
        exp_fp.push_back(expOf(0));
        exp_rr.push_back(expOf(1));
    endtask

    task automatic repeatStimulus(input int n, input logic [N-1:0] req, input logic [N-1:0] lock);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, req, lock, '0, 2'b00, 1'b1);
    endtask

    // Monitor: every post-edge sample is matched against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_rr.size() > 0 && exp_fp.size() > 0) begin
                e = exp_rr.pop_front();
                checkOutput("rr_grant", 32'(rr_grant), 32'(e.grant));
                checkOutput("rr_master", 32'(rr_master), 32'(e.master));
                checkOutput("rr_mastlock", 32'(rr_lock), 32'(e.lock));
                checkOutput("rr_splitmask", 32'(rr_mask), 32'(e.mask));
                checkOutput("rr_onehot", 32'($onehot(rr_grant)), 32'd1);
                e = exp_fp.pop_front();
                checkOutput("fp_grant", 32'(fp_grant), 32'(e.grant));
                checkOutput("fp_master", 32'(fp_master), 32'(e.master));
                checkOutput("fp_mastlock", 32'(fp_lock), 32'(e.lock));
                checkOutput("fp_splitmask", 32'(fp_mask), 32'(e.mask));
                checkOutput("fp_onehot", 32'($onehot(fp_grant)), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [N-1:0] rq, lk, sp;
        logic [1:0]   rs;
        modelReset();
        applyStimulus(1'b1, '0, '0, '0, 2'b00, 1'b1);
        applyStimulus(1'b1, '0, '0, '0, 2'b00, 1'b1);

        $display("[TB] idle after reset");
        repeatStimulus(20, '0, '0);

        $display("[TB] three requesters, hold limit rotation");
        repeatStimulus(30, 16'h000E, '0);

        $display("[TB] two requesters, then one drops");
        repeatStimulus(20, 16'h0006, '0);
        repeatStimulus(10, 16'h0004, '0);

        $display("[TB] locked owner");
        repeatStimulus(3, 16'h0008, '0);
        repeatStimulus(20, 16'hFFFF, 16'h0008);
        repeatStimulus(10, 16'hFFFF, '0);

        $display("[TB] split and resume");
        repeatStimulus(3, 16'h0020, '0);
        applyStimulus(1'b0, 16'hFFFF, '0, '0, 2'b11, 1'b1);
        repeatStimulus(8, 16'hFFFF, '0);
        applyStimulus(1'b0, 16'hFFFF, '0, 16'h0020, 2'b00, 1'b1);
        repeatStimulus(50, 16'hFFFF, '0);
        repeatStimulus(3, 16'h0020, '0);
        applyStimulus(1'b0, 16'h0020, '0, 16'h0020, 2'b11, 1'b1);
        repeatStimulus(3, 16'h0020, '0);

        $display("[TB] asynchronous reset during a stalled locked burst");
        repeatStimulus(4, 16'h0008, 16'h0008);
        applyStimulus(1'b0, 16'h0008, 16'h0008, '0, 2'b00, 1'b0);
        @(posedge HCLK);
        #3;
        HRESET = 1'b1;
        #1;
        checkOutput("async_rr_grant", 32'(rr_grant), 32'h0001);
        checkOutput("async_rr_master", 32'(rr_master), 32'd0);
        checkOutput("async_rr_mastlock", 32'(rr_lock), 32'd0);
        checkOutput("async_fp_grant", 32'(fp_grant), 32'h0001);
        checkOutput("async_fp_mastlock", 32'(fp_lock), 32'd0);
        modelReset();
        applyStimulus(1'b1, 16'h0008, 16'h0008, '0, 2'b00, 1'b0);
        applyStimulus(1'b0, 16'h0008, '0, '0, 2'b00, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            rq = 16'($urandom) & 16'($urandom | $urandom);
            lk = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
            sp = ($urandom_range(0, 3) == 0) ? (16'(1) << $urandom_range(0, N - 1)) : '0;
            rs = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            applyStimulus(1'b0, rq, lk, sp, rs, ($urandom_range(0, 4) != 0));
        end

        applyStimulus(1'b0, '0, '0, '0, 2'b00, 1'b1);
        @(posedge HCLK);
        #2;
        checkOutput("queue_drained", 32'(exp_rr.size() + exp_fp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
